// File: rtl/bus_reg_responder.sv
// 68000-style bus target: register window decode, wait states, DTACK and a byte-writable register file.
// Optional write-event FIFO with DTACK backpressure is enabled by defining BUS_REG_RESPONDER_EVFIFO_EN.
module bus_reg_responder #(
   parameter logic [23:0] BASE_ADDR   = 24'hff8200,
   parameter int          ADDR_BITS   = 6,
   parameter int          WAIT_STATES = 2
) (
   input  logic                 clk32,
   input  logic                 reset,
   input  logic                 bus_en,
   input  logic                 as_n,
   input  logic                 rw,
   input  logic                 uds_n,
   input  logic                 lds_n,
   input  logic [23:1]          a,
   input  logic [15:0]          din,
   output logic [15:0]          dout,
   output logic                 oe,
   output logic                 dtack_n,
   input  logic [ADDR_BITS-1:0] reg_rd_addr,
   output logic [15:0]          reg_rd_data,
   output logic                 ev_valid,
   input  logic                 ev_ready,
   output logic [ADDR_BITS-1:0] ev_addr,
   output logic [15:0]          ev_data,
   output logic [1:0]           ev_be
);

   localparam int CW    = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
   localparam int NREGS = 1 << ADDR_BITS;

   typedef enum logic [1:0] {ST_SYNC, ST_IDLE, ST_WAIT, ST_ACK} state_t;

   state_t               state, state_next;
   logic [CW-1:0]        cnt, cnt_next;
   logic                 hit, strobe, stall;
   logic [ADDR_BITS-1:0] word_idx;
   logic                 do_access, do_write, do_read, ack_release;
   logic [15:0]          regs [NREGS];

   assign hit      = (a[23:ADDR_BITS+1] == BASE_ADDR[23:ADDR_BITS+1]);
   assign word_idx = a[ADDR_BITS:1];
   assign strobe   = !uds_n || !lds_n;

   always_ff @(posedge clk32) begin
      if (reset) begin
         state <= ST_SYNC;
         cnt   <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   // A write that is ready to go while the event FIFO is full simply stays in WAIT
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      unique case (state)
         ST_SYNC: if (bus_en && as_n) state_next = ST_IDLE;
         ST_IDLE: begin
            if (bus_en && !as_n && strobe && hit) begin
               state_next = ST_WAIT;
               cnt_next   = CW'(WAIT_STATES);
            end
         end
         ST_WAIT: begin
            if (bus_en) begin
               if (as_n)            state_next = ST_IDLE;
               else if (cnt != '0)  cnt_next   = cnt - 1'b1;
               else if (!stall)     state_next = ST_ACK;
            end
         end
         ST_ACK:  if (bus_en && as_n) state_next = ST_IDLE;
         default: state_next = ST_SYNC;
      endcase
   end

   always_comb begin
      do_access   = (state == ST_WAIT) && bus_en && !as_n && (cnt == '0) && !stall;
      do_write    = do_access && !rw;
      do_read     = do_access && rw;
      ack_release = (state == ST_ACK) && bus_en && as_n;
   end

   always_ff @(posedge clk32) begin
      if (reset) begin
         dout    <= '0;
         oe      <= 1'b0;
         dtack_n <= 1'b1;
      end else begin
         if (do_access) dtack_n <= 1'b0;
         if (do_read) begin
            dout <= regs[word_idx];
            oe   <= 1'b1;
         end
         if (ack_release) begin
            dtack_n <= 1'b1;
            oe      <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk32) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      end else if (do_write) begin
         if (!uds_n) regs[word_idx][15:8] <= din[15:8];
         if (!lds_n) regs[word_idx][7:0]  <= din[7:0];
      end
   end

   assign reg_rd_data = regs[reg_rd_addr];

`ifdef BUS_REG_RESPONDER_EVFIFO_EN
   logic [ADDR_BITS+17:0] fifo_mem [4];
   logic [1:0]            rd_ptr, wr_ptr;
   logic [2:0]            fifo_count;
   logic                  fifo_full, ev_pop;

   assign fifo_full = (fifo_count == 3'd4);
   assign ev_valid  = (fifo_count != 3'd0);
   assign ev_pop    = ev_valid && ev_ready;
   assign stall     = !rw && fifo_full && !ev_pop;
   assign {ev_addr, ev_data, ev_be} = ev_valid ? fifo_mem[rd_ptr] : '0;

   always_ff @(posedge clk32) begin
      if (reset) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (do_write) wr_ptr <= wr_ptr + 1'b1;
         if (ev_pop)   rd_ptr <= rd_ptr + 1'b1;
         fifo_count <= fifo_count + {2'b00, do_write} - {2'b00, ev_pop};
      end
   end

   always_ff @(posedge clk32) begin
      if (do_write) fifo_mem[wr_ptr] <= {word_idx, din, !uds_n, !lds_n};
   end
`else
   logic unused_ev_ready;
   assign unused_ev_ready = ev_ready;
   assign stall    = 1'b0;
   assign ev_valid = 1'b0;
   assign ev_addr  = '0;
   assign ev_data  = '0;
   assign ev_be    = '0;
`endif

endmodule

// File: tb/tb_bus_reg_responder.sv
// Randomised scoreboard bench for bus_reg_responder: reference register model plus ack/event monitors.
module tb_bus_reg_responder;

   localparam logic [23:0] BASE = 24'hff8200;
   localparam int          AB   = 6;
   localparam int          WS   = 2;

   logic          clk32    = 1'b0;
   logic          reset    = 1'b1;
   logic          as_n     = 1'b1;
   logic          rw       = 1'b1;
   logic          uds_n    = 1'b1;
   logic          lds_n    = 1'b1;
   logic          ev_ready = 1'b0;
   logic [23:1]   a        = '0;
   logic [15:0]   din      = '0;
   logic [AB-1:0] reg_rd_addr = '0;
   logic          bus_en;
   logic [15:0]   dout, reg_rd_data, ev_data;
   logic          oe, dtack_n, ev_valid;
   logic [AB-1:0] ev_addr;
   logic [1:0]    ev_be;

   logic [1:0]    div = '0;
   int            tick_cnt = 0;

   typedef struct {
      int          tick;
      bit          rd;
      logic [15:0] data;
   } ack_t;
   typedef logic [AB+17:0] ev_t;

   ack_t        ack_q[$];
   ev_t         ev_q[$];
   ack_t        mon_e;
   logic [15:0] model [64];
   int          checks    = 0;
   int          errors    = 0;
   int          ack_count = 0;
   logic        prev_dtack = 1'b1;

   bus_reg_responder #(.BASE_ADDR(BASE), .ADDR_BITS(AB), .WAIT_STATES(WS)) dut (
      .clk32(clk32), .reset(reset), .bus_en(bus_en), .as_n(as_n), .rw(rw),
      .uds_n(uds_n), .lds_n(lds_n), .a(a), .din(din), .dout(dout), .oe(oe),
      .dtack_n(dtack_n), .reg_rd_addr(reg_rd_addr), .reg_rd_data(reg_rd_data),
      .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_addr(ev_addr),
      .ev_data(ev_data), .ev_be(ev_be)
   );

   always #5 clk32 = ~clk32;

   // 8 MHz bus strobe: one clk32 cycle in four, with a running tick count for latency checks
   assign bus_en = (div == 2'd3);
   always @(posedge clk32) begin
      div <= div + 2'd1;
      if (bus_en) tick_cnt <= tick_cnt + 1;
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_ticks(input int n);
      int tgt;
      tgt = tick_cnt + n;
      while (tick_cnt < tgt) @(negedge clk32);
   endtask

   // Every falling DTACK must match the oldest expected response
   always @(posedge clk32) begin
      #1;
      if (prev_dtack && !dtack_n) begin
         ack_count++;
         if (ack_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_ack: dtack_n fell at tick %0d with nothing pending", tick_cnt);
         end else begin
            mon_e = ack_q.pop_front();
            if (mon_e.tick != 0) checkOutput("ack_tick", tick_cnt, mon_e.tick);
            checkOutput("ack_oe", {31'b0, oe}, {31'b0, mon_e.rd});
            if (mon_e.rd) checkOutput("read_data", {16'b0, dout}, {16'b0, mon_e.data});
         end
      end
      prev_dtack = dtack_n;
   end

`ifdef BUS_REG_RESPONDER_EVFIFO_EN
   always @(negedge clk32) begin
      #3;
      if (ev_valid && ev_ready) begin
         if (ev_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_event: addr %0h data %0h be %0b", ev_addr, ev_data, ev_be);
         end else begin
            checkOutput("event_payload", {8'b0, ev_addr, ev_data, ev_be}, {8'b0, ev_q.pop_front()});
         end
      end
   end
`endif

   // One complete bus cycle; the expected response and write effects come from the register model
   task automatic applyStimulus(input logic [23:0] addr, input bit rd, input bit u, input bit l,
                                input logic [15:0] data, input bit abort, input int stall_ticks);
      logic [AB-1:0] idx;
      bit            hit, expect_ack;
      int            k, start_ack, guard;
      ack_t          e;
      idx        = addr[AB:1];
      hit        = (((addr ^ BASE) >> (AB + 1)) == 24'd0);
      expect_ack = hit && (u || l) && !abort;
      @(negedge clk32);
      k         = tick_cnt;
      start_ack = ack_count;
      a     = addr[23:1];
      rw    = rd;
      uds_n = !u;
      lds_n = !l;
      din   = data;
      if (expect_ack) begin
         e.tick = (stall_ticks > 0) ? 0 : k + 2 + WS;
         e.rd   = rd;
         e.data = model[idx];
         if (!rd) begin
            if (u) model[idx][15:8] = data[15:8];
            if (l) model[idx][7:0]  = data[7:0];
`ifdef BUS_REG_RESPONDER_EVFIFO_EN
            ev_q.push_back({idx, data, u, l});
`endif
         end
         ack_q.push_back(e);
      end
      as_n = 1'b0;
      if (abort) begin
         wait_ticks(2);
      end else if (!expect_ack) begin
         wait_ticks(WS + 3);
      end else begin
         if (stall_ticks > 0) begin
            wait_ticks(WS + 1 + stall_ticks);
            checkOutput("stalled_no_ack", ack_count, start_ack);
            ev_ready = 1'b1;
         end
         guard = 0;
         while (ack_count == start_ack && guard < 400) begin
            @(negedge clk32);
            guard++;
         end
         checkOutput("ack_seen", ack_count, start_ack + 1);
         reg_rd_addr = idx;
         #1;
         checkOutput("side_read", {16'b0, reg_rd_data}, {16'b0, model[idx]});
         if (rd) checkOutput("oe_held", {31'b0, oe}, 32'd1);
      end
      if (!expect_ack) begin
         reg_rd_addr = idx;
         #1;
         checkOutput("no_change", {16'b0, reg_rd_data}, {16'b0, model[idx]});
      end
      @(negedge clk32);
      as_n  = 1'b1;
      uds_n = 1'b1;
      lds_n = 1'b1;
      wait_ticks(1);
      checkOutput("dtack_released", {31'b0, dtack_n}, 32'd1);
      checkOutput("oe_released", {31'b0, oe}, 32'd0);
      if (!expect_ack) checkOutput("no_ack", ack_count, start_ack);
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish, errors so far %0d", errors);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int k0, guard;
      ack_t e;
      for (int i = 0; i < 64; i++) model[i] = 16'h0;
      repeat (4) @(negedge clk32);
      checkOutput("reset_dtack", {31'b0, dtack_n}, 32'd1);
      checkOutput("reset_oe", {31'b0, oe}, 32'd0);
      checkOutput("reset_dout", {16'b0, dout}, 32'd0);
      checkOutput("reset_ev", {8'b0, ev_valid, ev_addr, ev_data, ev_be}, 32'd0);
      checkOutput("reset_regs", {16'b0, reg_rd_data}, 32'd0);
      reset    = 1'b0;
      ev_ready = 1'b1;
      wait_ticks(2);

      $display("[TB] directed cycles");
      applyStimulus(24'hff8240, 1'b0, 1'b1, 1'b1, 16'h0777, 1'b0, 0);
      reg_rd_addr = 6'h20;
      #1;
      checkOutput("word_write_0x20", {16'b0, reg_rd_data}, 32'h0777);
      applyStimulus(24'hff8242, 1'b0, 1'b1, 1'b0, 16'h07aa, 1'b0, 0);
      reg_rd_addr = 6'h21;
      #1;
      checkOutput("byte_write_0x21", {16'b0, reg_rd_data}, 32'h0700);
      applyStimulus(24'hff8242, 1'b1, 1'b1, 1'b1, 16'h0000, 1'b0, 0);
      applyStimulus(24'hff8000, 1'b0, 1'b1, 1'b1, 16'hbeef, 1'b0, 0);
      applyStimulus(24'hff8244, 1'b0, 1'b1, 1'b1, 16'h1234, 1'b1, 0);

      $display("[TB] random cycles");
      for (int n = 0; n < 40; n++) begin
         int          kind;
         logic [AB-1:0] ri;
         logic [1:0]  ul;
         logic [15:0] rdat;
         kind = $urandom_range(0, 9);
         ri   = AB'($urandom);
         ul   = 2'($urandom_range(1, 3));
         rdat = 16'($urandom);
         if (kind <= 3)
            applyStimulus(BASE + {17'b0, ri, 1'b0}, 1'b0, ul[1], ul[0], rdat, 1'b0, 0);
         else if (kind <= 6)
            applyStimulus(BASE + {17'b0, ri, 1'b0}, 1'b1, ul[1], ul[0], rdat, 1'b0, 0);
         else if (kind == 7)
            applyStimulus(24'hff8000 + {17'b0, ri, 1'b0}, 1'b0, 1'b1, 1'b1, rdat, 1'b0, 0);
         else if (kind == 8)
            applyStimulus(BASE + {17'b0, ri, 1'b0}, 1'b0, 1'b1, 1'b1, rdat, 1'b1, 0);
         else
            applyStimulus(BASE + {17'b0, ri, 1'b0}, 1'b0, 1'b0, 1'b0, rdat, 1'b0, 0);
      end

      $display("[TB] event backpressure");
      @(negedge clk32);
      ev_ready = 1'b0;
      for (int i = 0; i < 4; i++)
         applyStimulus(BASE + 24'(2 * (8 + i)), 1'b0, 1'b1, 1'b1, 16'($urandom), 1'b0, 0);
`ifdef BUS_REG_RESPONDER_EVFIFO_EN
      applyStimulus(BASE + 24'h20, 1'b0, 1'b1, 1'b1, 16'hcafe, 1'b0, 6);
      repeat (8) @(negedge clk32);
      checkOutput("events_drained", ev_q.size(), 0);
      checkOutput("fifo_empty", {31'b0, ev_valid}, 32'd0);
`else
      applyStimulus(BASE + 24'h20, 1'b0, 1'b1, 1'b1, 16'hcafe, 1'b0, 0);
      ev_ready = 1'b1;
      #1;
      checkOutput("ev_tied_off", {8'b0, ev_valid, ev_addr, ev_data, ev_be}, 32'd0);
`endif

      $display("[TB] reset during ACK");
      @(negedge clk32);
      k0    = ack_count;
      a     = 23'h7fc120;
      rw    = 1'b1;
      uds_n = 1'b0;
      lds_n = 1'b0;
      e.tick = tick_cnt + 2 + WS;
      e.rd   = 1'b1;
      e.data = model[6'h20];
      ack_q.push_back(e);
      as_n = 1'b0;
      guard = 0;
      while (ack_count == k0 && guard < 400) begin
         @(negedge clk32);
         guard++;
      end
      checkOutput("pre_reset_ack", ack_count, k0 + 1);
      reset = 1'b1;
      @(posedge clk32);
      #1;
      checkOutput("midreset_dtack", {31'b0, dtack_n}, 32'd1);
      checkOutput("midreset_oe", {31'b0, oe}, 32'd0);
      checkOutput("midreset_dout", {16'b0, dout}, 32'd0);
      @(negedge clk32);
      reset = 1'b0;
      for (int i = 0; i < 64; i++) model[i] = 16'h0;
      ev_q.delete();
      wait_ticks(3);
      checkOutput("no_ack_after_reset", ack_count, k0 + 1);
      reg_rd_addr = 6'h20;
      #1;
      checkOutput("regs_cleared", {16'b0, reg_rd_data}, 32'd0);
      as_n  = 1'b1;
      uds_n = 1'b1;
      lds_n = 1'b1;
      wait_ticks(1);
      applyStimulus(24'hff8240, 1'b1, 1'b1, 1'b1, 16'h0000, 1'b0, 0);
      applyStimulus(24'hff827e, 1'b0, 1'b0, 1'b1, 16'h5a3c, 1'b0, 0);
      applyStimulus(24'hff827e, 1'b1, 1'b1, 1'b1, 16'h0000, 1'b0, 0);

      repeat (8) @(negedge clk32);
      checkOutput("acks_outstanding", ack_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
